// File: rtl/hh_neuron_scheduler.sv
// hh_neuron_scheduler: walks N_NEURONS virtual Hodgkin-Huxley neurons through
// one shared ionic-current datapath per network timestep. Membrane potential,
// refractory counters and input currents are held here; the datapath only
// returns I_ion for the V it is given.
module hh_neuron_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int DT_SHIFT = 10,
  parameter logic signed [15:0] V_REST = -16'sd65,
  parameter logic signed [15:0] V_THRESH = 16'sd30,
  parameter int REFRAC_STEPS = 2,
  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [15:0]                 dt,
  input  logic                        step_req,
  output logic                        step_busy,
  output logic                        step_done,
  output logic [N_NEURONS-1:0]        spike_vec,
  input  logic                        cfg_we,
  input  logic [IDX_W-1:0]            cfg_idx,
  input  logic signed [15:0]          cfg_current,
  output logic                        dp_valid,
  input  logic                        dp_ready,
  output logic [IDX_W-1:0]            dp_idx,
  output logic signed [15:0]          dp_v,
  input  logic                        dp_resp_valid,
  input  logic signed [15:0]          dp_i_ion,
  output logic signed [15:0]          v_out
);

  // A counter wide enough to hold REFRAC_STEPS; one bit minimum when disabled.
  localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [RW-1:0] REFRAC_LOAD = RW'(REFRAC_STEPS);
  localparam logic [N_NEURONS-1:0] ONE_HOT0 = {{(N_NEURONS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_DONE} state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [15:0]                  r_dt;
  logic [IDX_W-1:0]             r_idx;
  logic signed [15:0]           r_i_ion;
  logic [N_NEURONS-1:0]         r_spike_work;
  logic [N_NEURONS-1:0]         r_spike_vec;
  logic signed [15:0]           r_v_out;

  logic signed [15:0]           r_v      [N_NEURONS];
  logic [RW-1:0]                r_refrac [N_NEURONS];
  logic signed [15:0]           r_i_in   [N_NEURONS];

  logic signed [15:0]           w_v_cur;
  logic signed [15:0]           w_i_in_cur;
  logic                         w_refr_cur;
  logic                         w_refr_nxt;
  logic                         w_is_last;
  logic [IDX_W-1:0]             w_idx_inc;
  logic signed [16:0]           w_diff;
  logic signed [32:0]           w_prod;
  logic signed [32:0]           w_delta;
  logic signed [33:0]           w_sum;
  logic signed [15:0]           w_sat;
  logic signed [15:0]           w_v_new;
  logic                         w_spike;
  logic                         w_new_spike;
  logic [N_NEURONS-1:0]         w_spike_bits;
  logic [N_NEURONS-1:0]         w_upd_hit;
  logic [N_NEURONS-1:0]         w_cfg_hit;

  // Per-neuron select lines: which neuron is being updated / configured.
  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_sel
      assign w_upd_hit[gi] = (r_state == S_UPDATE) && (r_idx == IDX_W'(gi));
      assign w_cfg_hit[gi] = cfg_we && (cfg_idx == IDX_W'(gi));
    end
  endgenerate

  assign w_v_cur    = r_v[r_idx];
  assign w_i_in_cur = r_i_in[r_idx];
  assign w_refr_cur = (r_refrac[r_idx] != '0);
  assign w_is_last  = (r_idx == LAST_IDX);
  assign w_idx_inc  = r_idx + 1'b1;
  // Only consulted when r_idx is not the last neuron, so the index is in range.
  assign w_refr_nxt = (r_refrac[w_idx_inc] != '0);

  // Euler step: V += ((I_in - I_ion) * dt) >>> DT_SHIFT, carried wide enough
  // that no intermediate can wrap before the final saturation.
  assign w_diff  = $signed({w_i_in_cur[15], w_i_in_cur}) - $signed({r_i_ion[15], r_i_ion});
  assign w_prod  = $signed({{16{w_diff[16]}}, w_diff}) * $signed({17'd0, r_dt});
  assign w_delta = w_prod >>> DT_SHIFT;
  assign w_sum   = $signed({{18{w_v_cur[15]}}, w_v_cur}) + $signed({w_delta[32], w_delta});

  // Clamp the integrated potential into the signed 16-bit range.
  always_comb begin
    w_sat = w_sum[15:0];
    if (w_sum > 34'sd32767) begin
      w_sat = 16'sh7FFF;
    end else if (w_sum < -34'sd32768) begin
      w_sat = 16'sh8000;
    end
  end

  assign w_spike      = (w_sat >= V_THRESH);
  assign w_new_spike  = !w_refr_cur && w_spike;
  assign w_v_new      = (w_refr_cur || w_spike) ? V_REST : w_sat;
  assign w_spike_bits = r_spike_work | (w_new_spike ? (ONE_HOT0 << r_idx) : '0);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore outputs; refractory neurons bypass the datapath.
  always_comb begin
    w_state_next = r_state;
    step_busy    = 1'b1;
    step_done    = 1'b0;
    dp_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        step_busy = 1'b0;
        if (step_req) begin
          w_state_next = (r_refrac[0] != '0) ? S_UPDATE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        dp_valid = 1'b1;
        if (dp_ready) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dp_resp_valid) begin
          w_state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (w_is_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = w_refr_nxt ? S_UPDATE : S_ISSUE;
        end
      end
      S_DONE: begin
        step_done    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Step bookkeeping: dt latch, neuron index, captured I_ion, spike results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dt         <= '0;
      r_idx        <= '0;
      r_i_ion      <= '0;
      r_spike_work <= '0;
      r_spike_vec  <= '0;
      r_v_out      <= V_REST;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (step_req) begin
            r_dt         <= dt;
            r_idx        <= '0;
            r_spike_work <= '0;
          end
        end
        S_WAIT: begin
          if (dp_resp_valid) begin
            r_i_ion <= dp_i_ion;
          end
        end
        S_UPDATE: begin
          r_v_out      <= w_v_new;
          r_spike_work <= w_spike_bits;
          // Publish the spike vector as DONE is entered so it is valid with step_done.
          if (w_is_last) begin
            r_spike_vec <= w_spike_bits;
          end else begin
            r_idx <= w_idx_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Per-neuron membrane, refractory and input-current state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_v[i]      <= V_REST;
        r_refrac[i] <= '0;
        r_i_in[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (w_cfg_hit[i]) begin
          r_i_in[i] <= cfg_current;
        end
        if (w_upd_hit[i]) begin
          r_v[i] <= w_v_new;
          if (w_refr_cur) begin
            r_refrac[i] <= r_refrac[i] - 1'b1;
          end else if (w_spike) begin
            r_refrac[i] <= REFRAC_LOAD;
          end
        end
      end
    end
  end

  assign spike_vec = r_spike_vec;
  assign dp_idx    = r_idx;
  assign dp_v      = w_v_cur;
  assign v_out     = r_v_out;

endmodule

// File: tb/tb_hh_neuron_scheduler.sv
// Bench for hh_neuron_scheduler: a datapath stub answers requests with a
// per-neuron I_ion table; a behavioural neuron model predicts every datapath
// request and every step result, which a scoreboard compares as they appear.
module tb_hh_neuron_scheduler;

  localparam int N = 4;

  logic               clock;
  logic               reset;
  logic [15:0]        dt;
  logic               step_req;
  logic               step_busy;
  logic               step_done;
  logic [N-1:0]       spike_vec;
  logic               cfg_we;
  logic [1:0]         cfg_idx;
  logic signed [15:0] cfg_current;
  logic               dp_valid;
  logic               dp_ready;
  logic [1:0]         dp_idx;
  logic signed [15:0] dp_v;
  logic               dp_resp_valid;
  logic signed [15:0] dp_i_ion;
  logic signed [15:0] v_out;

  logic               stub_ready;
  logic               stub_resp;
  logic signed [15:0] stub_i_drv;
  logic               late_resp;

  assign dp_ready      = stub_ready;
  assign dp_resp_valid = stub_resp | late_resp;
  assign dp_i_ion      = late_resp ? 16'sh1234 : stub_i_drv;

  hh_neuron_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .dt           (dt),
    .step_req     (step_req),
    .step_busy    (step_busy),
    .step_done    (step_done),
    .spike_vec    (spike_vec),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_current  (cfg_current),
    .dp_valid     (dp_valid),
    .dp_ready     (dp_ready),
    .dp_idx       (dp_idx),
    .dp_v         (dp_v),
    .dp_resp_valid(dp_resp_valid),
    .dp_i_ion     (dp_i_ion),
    .v_out        (v_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int idx; int v; } dp_exp_t;
  typedef struct { int spikes; int vout; int lat; } step_exp_t;

  dp_exp_t   dp_q[$];
  step_exp_t st_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int req_cyc  = 0;
  int done_cnt = 0;
  int held_hit = 0;

  int m_v[N];
  int m_ref[N];
  int m_iin[N];
  int stub_ion[N];

  int stall_len  = 0;
  int stall_tok  = 0;
  int stall_seen = 0;
  int stall_cnt  = 0;
  int hold_en    = 0;
  int hold_idx   = 0;
  int resp_due   = 0;
  int resp_idx   = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(posedge clock) cyc++;

  // Behavioural model of one full timestep; queues the expected traffic.
  function automatic void model_step(input int dtv, input int stall);
    longint diff, prod, delta, s;
    int first, lat, spk;
    first = 1; lat = 1; spk = 0;
    for (int i = 0; i < N; i++) begin
      if (m_ref[i] > 0) begin
        m_v[i] = -65;
        m_ref[i] = m_ref[i] - 1;
        lat += 1;
      end else begin
        dp_q.push_back('{i, m_v[i]});
        diff  = longint'(m_iin[i]) - longint'(stub_ion[i]);
        prod  = diff * longint'(dtv);
        delta = prod >>> 10;
        s     = longint'(m_v[i]) + delta;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (s >= 30) begin
          spk |= (1 << i);
          m_v[i] = -65;
          m_ref[i] = 2;
        end else begin
          m_v[i] = int'(s);
        end
        lat += 3;
        if (first == 1) lat += stall;
        first = 0;
      end
    end
    st_q.push_back('{spk, m_v[N-1], lat});
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = -65; m_ref[i] = 0; m_iin[i] = 0;
    end
  endfunction

  // Datapath stub plus scoreboard: decide ready/response for the coming edge
  // and compare whatever the DUT presents in this cycle.
  always @(negedge clock) begin
    if (reset) begin
      stub_ready = 1'b0;
      stub_resp  = 1'b0;
      resp_due   = 0;
    end else begin
      stub_resp = 1'b0;
      if (resp_due != 0) begin
        stub_resp  = 1'b1;
        stub_i_drv = 16'(stub_ion[resp_idx]);
        resp_due   = 0;
      end
      if (dp_valid && stall_tok != stall_seen) begin
        stall_cnt  = stall_len;
        stall_seen = stall_tok;
      end
      if (dp_valid && stall_cnt > 0) begin
        stub_ready = 1'b0;
        stall_cnt--;
        if (dp_q.size() > 0) begin
          check_val("stall_dp_idx", dp_idx, dp_q[0].idx);
          check_val("stall_dp_v", dp_v, dp_q[0].v);
        end
      end else begin
        stub_ready = 1'b1;
      end
      if (dp_valid && stub_ready) begin
        $display("dp request idx=%0d v=%0d", dp_idx, dp_v);
        if (dp_q.size() == 0) begin
          check_val("dp_unexpected", dp_idx, -1);
        end else begin
          dp_exp_t e;
          e = dp_q.pop_front();
          check_val("dp_idx", dp_idx, e.idx);
          check_val("dp_v", dp_v, e.v);
        end
        if (hold_en != 0 && int'(dp_idx) == hold_idx) begin
          held_hit++;
        end else begin
          resp_due = 1;
          resp_idx = int'(dp_idx);
        end
      end
      if (step_done) begin
        done_cnt++;
        $display("step done spikes=%b v_out=%0d latency=%0d", spike_vec, v_out, cyc - req_cyc);
        if (st_q.size() == 0) begin
          check_val("step_unexpected", done_cnt, -1);
        end else begin
          step_exp_t s;
          s = st_q.pop_front();
          check_val("spike_vec", spike_vec, s.spikes);
          check_val("v_out", v_out, s.vout);
          check_val("latency", cyc - req_cyc, s.lat);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic cfg_write(input int idx, input int val);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_current = 16'(val);
    m_iin[idx] = val;
    tick();
    cfg_we = 1'b0;
  endtask

  // One timestep: optional initial ready stall, optional cfg write during
  // neuron 0, optional stray step_req while busy.
  task automatic run_step(input int dtv, input int stall, input int mid_en,
                          input int mid_idx, input int mid_val, input int pulse_at);
    int start;
    stall_len = stall;
    if (stall > 0) stall_tok++;
    if (mid_en != 0) m_iin[mid_idx] = mid_val;
    model_step(dtv, stall);
    start    = done_cnt;
    dt       = 16'(dtv);
    step_req = 1'b1;
    req_cyc  = cyc;
    tick();
    step_req = 1'b0;
    dt       = 16'h0003;
    check_val("busy_after_req", step_busy, 1);
    for (int k = 0; k < 300 && done_cnt == start; k++) begin
      cfg_we = (mid_en != 0 && k == 0);
      if (mid_en != 0 && k == 0) begin
        cfg_idx = 2'(mid_idx); cfg_current = 16'(mid_val);
      end
      step_req = (k == pulse_at);
      tick();
    end
    cfg_we = 1'b0; step_req = 1'b0;
    if (done_cnt == start) check_val("step_timeout", 0, 1);
    repeat (3) tick();
    check_val("done_count", done_cnt - start, 1);
    check_val("busy_idle", step_busy, 0);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_busy", step_busy, 0);
    check_val("rst_done", step_done, 0);
    check_val("rst_dp_valid", dp_valid, 0);
    check_val("rst_dp_idx", dp_idx, 0);
    check_val("rst_dp_v", dp_v, -65);
    check_val("rst_v_out", v_out, -65);
    check_val("rst_spike_vec", spike_vec, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, dsnap;
    reset = 1'b1; dt = '0; step_req = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_current = '0; late_resp = 1'b0; stub_i_drv = '0;
    stub_ready = 1'b0; stub_resp = 1'b0;
    for (int i = 0; i < N; i++) stub_ion[i] = 0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs();
    reset = 1'b0;
    tick();

    // Quiescent step: nothing moves, 13-cycle latency.
    run_step(1024, 0, 0, 0, 0, -1);

    // Neuron 2 spikes, sits out two steps, then issues again.
    cfg_write(2, 100);
    repeat (4) run_step(1024, 0, 0, 0, 0, -1);

    // Extreme currents and dt: clamp high (spike) and clamp low (no wrap).
    cfg_write(0, 32767);
    cfg_write(1, -32768);
    cfg_write(2, 0);
    stub_ion[0] = -32768; stub_ion[1] = 32767;
    repeat (2) run_step(65535, 0, 0, 0, 0, -1);

    // Ready held low 5 cycles; stray step_req during the stall.
    stub_ion[0] = 0; stub_ion[1] = 0;
    run_step(1024, 5, 0, 0, 0, 2);

    // Reset while waiting for neuron 1's response.
    hold_en = 1; hold_idx = 1;
    snap = held_hit;
    dsnap = done_cnt;
    model_step(1024, 0);
    dt = 16'd1024; step_req = 1'b1; req_cyc = cyc;
    tick();
    step_req = 1'b0;
    for (int k = 0; k < 100 && held_hit == snap; k++) tick();
    if (held_hit == snap) check_val("hold_timeout", 0, 1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    dp_q.delete();
    st_q.delete();
    model_reset();
    hold_en = 0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    late_resp = 1'b1;
    tick();
    late_resp = 1'b0;
    repeat (2) tick();
    check_val("late_resp_busy", step_busy, 0);
    check_val("late_resp_dp_valid", dp_valid, 0);
    check_val("late_resp_v_out", v_out, -65);
    check_val("late_resp_no_done", done_cnt - dsnap, 0);

    // Clean restart; neuron 3's current written during neuron 0 takes effect.
    run_step(1024, 0, 1, 3, 200, -1);

    // Sub-threshold negative drive on neuron 3 after its refractory period.
    cfg_write(3, -50);
    repeat (3) run_step(2048, 0, 0, 0, 0, -1);

    check_val("dp_queue_empty", dp_q.size(), 0);
    check_val("step_queue_empty", st_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
